// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the datapath (master) and the 7-segment scan controller (slave).
// load is a one-cycle capture strobe with no back-pressure: the controller takes num_flat/dp_in on every cycle it is high.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   num_flat;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     dig_sel;

  modport master (
    output en, load, num_flat, dp_in, blank_lz,
    input  seg, dp, dig_sel
  );

  modport slave (
    input  en, load, num_flat, dp_in, blank_lz,
    output seg, dp, dig_sel
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver: shadow capture, prescaled digit scan,
// decimal/hex decode with leading-zero blanking and per-pin polarity control.
module seg_scan_ctrl #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit HEX_EN         = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_ctrl_if.slave   bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]          pcnt;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic [DIGITS-1:0][3:0] shadow_num;
  logic [DIGITS-1:0]      shadow_dp;
  logic [DIGITS-1:0]      zero_run;
  logic [3:0]             cur_val;
  logic                   cur_blank;
  logic [DIGITS-1:0]      sel_next;
  logic [6:0]             seg_q;
  logic                   dp_q;
  logic [DIGITS-1:0]      sel_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd10:   s = HEX_EN ? 7'b1110111 : 7'b0000001;
      4'd11:   s = HEX_EN ? 7'b0011111 : 7'b0000001;
      4'd12:   s = HEX_EN ? 7'b1001110 : 7'b0000001;
      4'd13:   s = HEX_EN ? 7'b0111101 : 7'b0000001;
      4'd14:   s = HEX_EN ? 7'b1001111 : 7'b0000001;
      default: s = HEX_EN ? 7'b1000111 : 7'b0000001;
    endcase
    return s;
  endfunction

  assign tick = (pcnt == PCNT_LAST);

  // Disabling the scan parks it at digit 0 so re-enabling always starts a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_num <= '0;
      shadow_dp  <= '0;
    end else if (bus.load) begin
      shadow_num <= bus.num_flat;
      shadow_dp  <= bus.dp_in;
    end
  end

  // zero_run[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_run = '0;
    zero_run[DIGITS-1] = (shadow_num[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_run[i] = (shadow_num[i] == 4'd0) && zero_run[i+1];
    end
  end

  always_comb begin
    cur_val   = shadow_num[idx];
    cur_blank = bus.blank_lz && (idx != '0) && zero_run[idx];
    sel_next  = '0;
    sel_next[idx] = 1'b1;
  end

  // Registered outputs hold active-high values; polarity is applied after the flops.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      seg_q <= cur_blank ? 7'b0000000 : decode(cur_val);
      dp_q  <= shadow_dp[idx];
      sel_q <= sel_next;
    end
  end

  assign bus.seg     = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign bus.dp      = dp_q ^ SEG_ACTIVE_LOW;
  assign bus.dig_sel = sel_q ^ {DIGITS{DIG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized traffic against a frame-position model.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();
  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus_dash ();

  assign bus_dash.en       = bus.en;
  assign bus_dash.load     = bus.load;
  assign bus_dash.num_flat = bus.num_flat;
  assign bus_dash.dp_in    = bus.dp_in;
  assign bus_dash.blank_lz = bus.blank_lz;

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .DIV(DIV), .HEX_EN(1'b1),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .DIV(DIV), .HEX_EN(1'b0),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_dash (
    .clk(clk), .rst(rst), .bus(bus_dash.slave)
  );

  // Reference model: shadow contents plus the number of enabled cycles since the scan restarted.
  logic [6:0]        seg_tab [16];
  logic [3:0]        m_num [DIGITS];
  logic              m_dp [DIGITS];
  int                m_run;
  logic [6:0]        exp_seg;
  logic [6:0]        exp_dash;
  logic              exp_dp;
  logic [DIGITS-1:0] exp_sel;

  // Computes what the outputs must read after the coming edge, then advances the model and the clock.
  task automatic tick();
    int d;
    bit zero_hi;
    if (rst || !bus.en) begin
      exp_seg  = 7'b0;
      exp_dash = 7'b0;
      exp_dp   = 1'b0;
      exp_sel  = '1;
    end else begin
      d = (m_run / DIV) % DIGITS;
      zero_hi = 1'b1;
      for (int j = d; j < DIGITS; j++) if (m_num[j] != 4'd0) zero_hi = 1'b0;
      exp_sel = ~(DIGITS'(1) << d);
      exp_dp  = m_dp[d];
      if (bus.blank_lz && d > 0 && zero_hi) begin
        exp_seg  = 7'b0;
        exp_dash = 7'b0;
      end else begin
        exp_seg  = seg_tab[m_num[d]];
        exp_dash = (m_num[d] > 4'd9) ? 7'b0000001 : seg_tab[m_num[d]];
      end
    end
    if (rst) begin
      for (int j = 0; j < DIGITS; j++) begin
        m_num[j] = 4'd0;
        m_dp[j]  = 1'b0;
      end
      m_run = 0;
    end else begin
      if (bus.load) begin
        for (int j = 0; j < DIGITS; j++) begin
          m_num[j] = bus.num_flat[4*j +: 4];
          m_dp[j]  = bus.dp_in[j];
        end
      end
      m_run = bus.en ? m_run + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_start(input logic [4*DIGITS-1:0] num, input logic [DIGITS-1:0] dps);
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.num_flat = num;
    bus.dp_in = dps;
    tick();
    bus.load = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.num_flat = '0;
    bus.dp_in = '0;
    bus.blank_lz = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.seg !== 7'b0000000) begin n_bad++; $display("FAIL reset_seg: got %b expected 0000000", bus.seg); end
    n_cmp++;
    if (bus.dp !== 1'b0) begin n_bad++; $display("FAIL reset_dp: got %b expected 0", bus.dp); end
    n_cmp++;
    if (bus.dig_sel !== 4'b1111) begin n_bad++; $display("FAIL reset_sel: got %b expected 1111", bus.dig_sel); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1110) begin n_bad++; $display("FAIL release_sel: got %b expected 1110", bus.dig_sel); end
  endtask

  task automatic test_scan();
    logic [3:0] sel_exp [4];
    logic [6:0] seg_exp [4];
    logic [3:0] dp_pat;
    int k;
    sel_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    dp_pat = 4'b1010;
    do_reset();
    load_start(16'h4321, dp_pat);
    for (int i = 0; i < 16; i++) begin
      tick();
      k = i / 4;
      n_cmp++;
      if (bus.dig_sel !== sel_exp[k]) begin n_bad++; $display("FAIL scan_sel[%0d]: got %b expected %b", i, bus.dig_sel, sel_exp[k]); end
      n_cmp++;
      if (bus.seg !== seg_exp[k]) begin n_bad++; $display("FAIL scan_seg[%0d]: got %b expected %b", i, bus.seg, seg_exp[k]); end
      n_cmp++;
      if (bus.dp !== dp_pat[k]) begin n_bad++; $display("FAIL scan_dp[%0d]: got %b expected %b", i, bus.dp, dp_pat[k]); end
    end
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1110) begin n_bad++; $display("FAIL scan_wrap: got %b expected 1110", bus.dig_sel); end
  endtask

  task automatic test_hex_dash();
    logic [6:0] seg_exp [4];
    int k;
    seg_exp = '{7'b1110111, 7'b0111101, 7'b1001111, 7'b1000111};
    do_reset();
    load_start(16'hFEDA, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      k = i / 4;
      n_cmp++;
      if (bus.seg !== seg_exp[k]) begin n_bad++; $display("FAIL hex_seg[%0d]: got %b expected %b", i, bus.seg, seg_exp[k]); end
      n_cmp++;
      if (bus_dash.seg !== 7'b0000001) begin n_bad++; $display("FAIL dash_seg[%0d]: got %b expected 0000001", i, bus_dash.seg); end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] sel_exp [4];
    logic [6:0] seg_exp [4];
    logic [3:0] dp_pat;
    logic [6:0] want;
    int k;
    sel_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
    dp_pat = 4'b0100;
    do_reset();
    bus.blank_lz = 1'b1;
    load_start(16'h0050, dp_pat);
    for (int i = 0; i < 16; i++) begin
      tick();
      k = i / 4;
      n_cmp++;
      if (bus.seg !== seg_exp[k]) begin n_bad++; $display("FAIL lz_seg[%0d]: got %b expected %b", i, bus.seg, seg_exp[k]); end
      n_cmp++;
      if (bus.dig_sel !== sel_exp[k]) begin n_bad++; $display("FAIL lz_sel[%0d]: got %b expected %b", i, bus.dig_sel, sel_exp[k]); end
      n_cmp++;
      if (bus.dp !== dp_pat[k]) begin n_bad++; $display("FAIL lz_dp[%0d]: got %b expected %b", i, bus.dp, dp_pat[k]); end
    end
    load_start(16'h0000, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      k = i / 4;
      want = (k == 0) ? 7'b1111110 : 7'b0000000;
      n_cmp++;
      if (bus.seg !== want) begin n_bad++; $display("FAIL lz_zero_seg[%0d]: got %b expected %b", i, bus.seg, want); end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_disable_race();
    do_reset();
    load_start(16'h4321, 4'b0000);
    repeat (6) tick();
    bus.en = 1'b0;
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1111) begin n_bad++; $display("FAIL dis_sel: got %b expected 1111", bus.dig_sel); end
    n_cmp++;
    if (bus.seg !== 7'b0000000) begin n_bad++; $display("FAIL dis_seg: got %b expected 0000000", bus.seg); end
    tick();
    bus.en = 1'b1;
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1110) begin n_bad++; $display("FAIL reen_sel: got %b expected 1110", bus.dig_sel); end
    tick();
    tick();
    bus.load = 1'b1;
    bus.num_flat = 16'h9876;
    tick();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.seg !== 7'b0110000) begin n_bad++; $display("FAIL race_old_seg: got %b expected 0110000", bus.seg); end
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1101) begin n_bad++; $display("FAIL race_sel: got %b expected 1101", bus.dig_sel); end
    n_cmp++;
    if (bus.seg !== 7'b1110000) begin n_bad++; $display("FAIL race_new_seg: got %b expected 1110000", bus.seg); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_start(16'h4321, 4'b0000);
    repeat (9) tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1011) begin n_bad++; $display("FAIL mid_pre_sel: got %b expected 1011", bus.dig_sel); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_sel: got %b expected 1111", bus.dig_sel); end
    n_cmp++;
    if (bus.seg !== 7'b0000000) begin n_bad++; $display("FAIL mid_rst_seg: got %b expected 0000000", bus.seg); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.dig_sel !== 4'b1110) begin n_bad++; $display("FAIL mid_rel_sel: got %b expected 1110", bus.dig_sel); end
    n_cmp++;
    if (bus.seg !== 7'b1111110) begin n_bad++; $display("FAIL mid_rel_seg: got %b expected 1111110", bus.seg); end
  endtask

  task automatic test_random();
    int r;
    logic [4*DIGITS-1:0] num;
    do_reset();
    bus.en = 1'b1;
    bus.blank_lz = 1'b1;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      bus.en = !(r >= 1 && r <= 2);
      bus.load = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < DIGITS; j++) begin
        num[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      bus.num_flat = num;
      bus.dp_in = DIGITS'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
      tick();
      n_cmp++;
      if (bus.seg !== exp_seg) begin n_bad++; $display("FAIL rnd_seg[%0d]: got %b expected %b", c, bus.seg, exp_seg); end
      n_cmp++;
      if (bus.dp !== exp_dp) begin n_bad++; $display("FAIL rnd_dp[%0d]: got %b expected %b", c, bus.dp, exp_dp); end
      n_cmp++;
      if (bus.dig_sel !== exp_sel) begin n_bad++; $display("FAIL rnd_sel[%0d]: got %b expected %b", c, bus.dig_sel, exp_sel); end
      n_cmp++;
      if (bus_dash.seg !== exp_dash) begin n_bad++; $display("FAIL rnd_dash[%0d]: got %b expected %b", c, bus_dash.seg, exp_dash); end
    end
    rst = 1'b0;
    bus.load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    for (int j = 0; j < DIGITS; j++) begin
      m_num[j] = 4'd0;
      m_dp[j]  = 1'b0;
    end
    m_run = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.num_flat = '0;
    bus.dp_in = '0;
    bus.blank_lz = 1'b0;

    test_reset();
    test_scan();
    test_hex_dash();
    test_lz_blank();
    test_disable_race();
    test_mid_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
